// File: rtl/sdram_params.svh
// Avalon-side widths shared by the SDRAM bridge and its neighbours.
`ifndef SDRAM_PARAMS_SVH
`define SDRAM_PARAMS_SVH

`define AVS_AW   24
`define AVS_DW   16
`define AVS_BYTE 2

`endif

// File: rtl/sdram_avs_bridge.sv
// Avalon-MM slave to SDRAM access-controller bridge: request FIFO plus read tracking.
// Optional macro SDRAM_AVS_RDATA_REG_EN registers the read-data return path.
`include "sdram_params.svh"

module sdram_avs_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RD     = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [`AVS_AW-1:0]     avs_address,
    input  logic [`AVS_DW-1:0]     avs_writedata,
    input  logic [`AVS_BYTE-1:0]   avs_byteenable,
    output logic                   avs_waitrequest,
    output logic [`AVS_DW-1:0]     avs_readdata,
    output logic                   avs_readdatavalid,
    output logic                   bus_req_valid,
    output logic                   bus_req_write,
    output logic [`AVS_AW-1:0]     bus_req_address,
    output logic [`AVS_DW-1:0]     bus_req_writedata,
    output logic [`AVS_BYTE-1:0]   bus_req_byteenable,
    input  logic                   bus_req_ready,
    input  logic                   bus_resp_valid,
    input  logic [`AVS_DW-1:0]     bus_resp_readdata,
    output logic                   bridge_idle,
    output logic                   resp_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + `AVS_AW + `AVS_DW + `AVS_BYTE;
    localparam logic [2:0] MAX_RD_C = 3'(MAX_RD);

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr_r;
    logic [PW:0]   rd_ptr_r;
    logic [2:0]    rd_pending_r;
    logic          resp_err_r;

    logic          empty_s;
    logic          full_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          rd_inc_s;
    logic          rd_dec_s;
    logic          is_write_s;
    logic [EW-1:0] push_entry_s;
    logic [EW-1:0] head_entry_s;

    // Occupancy flags from the extra-MSB pointer scheme.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                  (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    end

    // Stall on a full queue, or on a pure read once the read budget is used up.
    always_comb begin
        if (full_s) begin
            avs_waitrequest = 1'b1;
        end else if (avs_read && !avs_write && (rd_pending_r == MAX_RD_C)) begin
            avs_waitrequest = 1'b1;
        end else begin
            avs_waitrequest = 1'b0;
        end
    end

    // Handshake decode; a simultaneous read+write is taken as a write.
    always_comb begin
        accept_s     = (avs_read || avs_write) && !avs_waitrequest;
        is_write_s   = avs_write;
        push_s       = accept_s;
        pop_s        = !empty_s && bus_req_ready;
        rd_inc_s     = accept_s && avs_read && !avs_write;
        rd_dec_s     = bus_resp_valid && (rd_pending_r != 3'd0);
        push_entry_s = {is_write_s, avs_address, avs_writedata, avs_byteenable};
    end

    // Request storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_r[PW-1:0]] <= push_entry_s;
        end else begin
            fifo_mem[wr_ptr_r[PW-1:0]] <= fifo_mem[wr_ptr_r[PW-1:0]];
        end
    end

    // FIFO pointers wrap naturally modulo 2*FIFO_DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Head-of-queue presentation to the access controller.
    always_comb begin
        head_entry_s       = fifo_mem[rd_ptr_r[PW-1:0]];
        bus_req_valid      = !empty_s;
        bus_req_write      = head_entry_s[EW-1];
        bus_req_address    = head_entry_s[EW-2 -: `AVS_AW];
        bus_req_writedata  = head_entry_s[`AVS_DW+`AVS_BYTE-1 -: `AVS_DW];
        bus_req_byteenable = head_entry_s[`AVS_BYTE-1:0];
    end

    // Outstanding-read counter; a stray response never drives it below zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending_r <= 3'd0;
        end else begin
            case ({rd_inc_s, rd_dec_s})
                2'b10:   rd_pending_r <= rd_pending_r + 3'd1;
                2'b01:   rd_pending_r <= rd_pending_r - 3'd1;
                default: rd_pending_r <= rd_pending_r;
            endcase
        end
    end

    // Sticky error: a response arrived while nothing was outstanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_err_r <= 1'b0;
        end else if (bus_resp_valid && (rd_pending_r == 3'd0)) begin
            resp_err_r <= 1'b1;
        end else begin
            resp_err_r <= resp_err_r;
        end
    end

    // Status outputs.
    always_comb begin
        resp_err    = resp_err_r;
        bridge_idle = empty_s && (rd_pending_r == 3'd0);
    end

`ifdef SDRAM_AVS_RDATA_REG_EN
    logic [`AVS_DW-1:0] rdata_r;
    logic               rvalid_r;

    // One-cycle registered return path; data captured only on a valid pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r  <= '0;
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= bus_resp_valid;
            if (bus_resp_valid) begin
                rdata_r <= bus_resp_readdata;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Drive the Avalon return signals from the registers.
    always_comb begin
        avs_readdata      = rdata_r;
        avs_readdatavalid = rvalid_r;
    end
`else
    // Zero-latency pass-through of the controller response.
    always_comb begin
        avs_readdata      = bus_resp_readdata;
        avs_readdatavalid = bus_resp_valid;
    end
`endif

endmodule

// File: tb/tb_sdram_avs_bridge.sv
// Directed self-checking bench for sdram_avs_bridge (FIFO_DEPTH=4, MAX_RD=2).
module tb_sdram_avs_bridge;

    logic        clk;
    logic        reset_n;
    logic        avs_read;
    logic        avs_write;
    logic [23:0] avs_address;
    logic [15:0] avs_writedata;
    logic [1:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [15:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        bus_req_valid;
    logic        bus_req_write;
    logic [23:0] bus_req_address;
    logic [15:0] bus_req_writedata;
    logic [1:0]  bus_req_byteenable;
    logic        bus_req_ready;
    logic        bus_resp_valid;
    logic [15:0] bus_resp_readdata;
    logic        bridge_idle;
    logic        resp_err;

    int n_cmp = 0;
    int n_err = 0;

    sdram_avs_bridge #(.FIFO_DEPTH(4), .MAX_RD(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .bus_req_valid(bus_req_valid), .bus_req_write(bus_req_write),
        .bus_req_address(bus_req_address), .bus_req_writedata(bus_req_writedata),
        .bus_req_byteenable(bus_req_byteenable), .bus_req_ready(bus_req_ready),
        .bus_resp_valid(bus_resp_valid), .bus_resp_readdata(bus_resp_readdata),
        .bridge_idle(bridge_idle), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One response pulse; return-path latency depends on the build option.
    task automatic resp_pulse(input logic [15:0] data, input string tag);
        bus_resp_valid    = 1'b1;
        bus_resp_readdata = data;
        #1;
`ifndef SDRAM_AVS_RDATA_REG_EN
        chk({tag, "_rdv"}, 32'(avs_readdatavalid), 32'd1);
        chk({tag, "_rdata"}, 32'(avs_readdata), 32'(data));
`endif
        tick();
        bus_resp_valid = 1'b0;
        #1;
`ifdef SDRAM_AVS_RDATA_REG_EN
        chk({tag, "_rdv"}, 32'(avs_readdatavalid), 32'd1);
        chk({tag, "_rdata"}, 32'(avs_readdata), 32'(data));
`else
        chk({tag, "_rdv_off"}, 32'(avs_readdatavalid), 32'd0);
`endif
    endtask

    initial begin
        reset_n = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
        avs_address = 24'h0; avs_writedata = 16'h0; avs_byteenable = 2'b00;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_readdata = 16'h0;

        // Reset state
        #12;
        chk("rst_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_wait", 32'(avs_waitrequest), 32'd0);
        chk("rst_idle", 32'(bridge_idle), 32'd1);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_rdv", 32'(avs_readdatavalid), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single write, ready high
        avs_write = 1'b1; avs_address = 24'h10; avs_writedata = 16'hA5A5;
        avs_byteenable = 2'b11; bus_req_ready = 1'b1;
        #1 chk("w1_wait", 32'(avs_waitrequest), 32'd0);
        tick();
        avs_write = 1'b0;
        #1;
        chk("w1_valid", 32'(bus_req_valid), 32'd1);
        chk("w1_write", 32'(bus_req_write), 32'd1);
        chk("w1_addr", 32'(bus_req_address), 32'h10);
        chk("w1_data", 32'(bus_req_writedata), 32'hA5A5);
        chk("w1_be", 32'(bus_req_byteenable), 32'h3);
        chk("w1_idle_busy", 32'(bridge_idle), 32'd0);
        tick();
        chk("w1_popped", 32'(bus_req_valid), 32'd0);
        chk("w1_idle", 32'(bridge_idle), 32'd1);

        // Fill the FIFO with ready low, then drain in order
        bus_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            avs_write = 1'b1; avs_address = 24'h20 + 24'(i);
            avs_writedata = 16'h1000 + 16'(i); avs_byteenable = 2'(i);
            #1 chk("fill_wait", 32'(avs_waitrequest), 32'd0);
            tick();
        end
        avs_address = 24'h24; avs_writedata = 16'h1004; avs_byteenable = 2'b10;
        #1;
        chk("full_wait", 32'(avs_waitrequest), 32'd1);
        chk("full_head", 32'(bus_req_address), 32'h20);
        chk("full_head_be", 32'(bus_req_byteenable), 32'h0);
        bus_req_ready = 1'b1;
        tick();
        chk("drop_wait", 32'(avs_waitrequest), 32'd0);
        chk("drain_h1", 32'(bus_req_address), 32'h21);
        tick();
        avs_write = 1'b0;
        #1;
        chk("drain_h2", 32'(bus_req_address), 32'h22);
        chk("drain_d2", 32'(bus_req_writedata), 32'h1002);
        tick();
        chk("drain_h3", 32'(bus_req_address), 32'h23);
        tick();
        chk("drain_h4", 32'(bus_req_address), 32'h24);
        chk("drain_d4", 32'(bus_req_writedata), 32'h1004);
        tick();
        chk("drain_empty", 32'(bus_req_valid), 32'd0);

        // Read limit of 2 outstanding
        avs_read = 1'b1; avs_address = 24'h40;
        tick();
        avs_address = 24'h41;
        #1;
        chk("rd0_valid", 32'(bus_req_valid), 32'd1);
        chk("rd0_write", 32'(bus_req_write), 32'd0);
        chk("rd0_addr", 32'(bus_req_address), 32'h40);
        tick();
        avs_address = 24'h42;
        #1 chk("rd_limit_wait", 32'(avs_waitrequest), 32'd1);
        tick();
        chk("rd_limit_nopush", 32'(bus_req_valid), 32'd0);
        chk("rd_limit_idle", 32'(bridge_idle), 32'd0);
        resp_pulse(16'h1234, "resp1234");
        chk("rd_limit_release", 32'(avs_waitrequest), 32'd0);
        tick();
        avs_read = 1'b0;
        #1;
        chk("rd3_addr", 32'(bus_req_address), 32'h42);
        chk("rd3_valid", 32'(bus_req_valid), 32'd1);
        tick();
        resp_pulse(16'hBEEF, "respBEEF");
        resp_pulse(16'hCAFE, "respCAFE");
        chk("rd_drained_idle", 32'(bridge_idle), 32'd1);
        chk("rd_no_err", 32'(resp_err), 32'd0);

        // Spurious response
        resp_pulse(16'h5555, "spurious");
        chk("spur_err", 32'(resp_err), 32'd1);
        chk("spur_idle", 32'(bridge_idle), 32'd1);
        avs_read = 1'b1; avs_address = 24'h50;
        tick();
        avs_address = 24'h51;
        tick();
        avs_address = 24'h52;
        #1 chk("spur_cnt_wait", 32'(avs_waitrequest), 32'd1);
        avs_read = 1'b0;
        tick();
        resp_pulse(16'h0001, "spur_d1");
        resp_pulse(16'h0002, "spur_d2");
        chk("spur_err_sticky", 32'(resp_err), 32'd1);
        chk("spur_idle2", 32'(bridge_idle), 32'd1);

        // Read and write together becomes a single write
        bus_req_ready = 1'b0;
        avs_read = 1'b1; avs_write = 1'b1; avs_address = 24'h60; avs_writedata = 16'h6666;
        tick();
        avs_read = 1'b0; avs_write = 1'b0;
        #1;
        chk("rw_write", 32'(bus_req_write), 32'd1);
        chk("rw_addr", 32'(bus_req_address), 32'h60);
        bus_req_ready = 1'b1;
        tick();
        chk("rw_single", 32'(bus_req_valid), 32'd0);
        chk("rw_no_pending", 32'(bridge_idle), 32'd1);

        // Reset with queued work discards it
        bus_req_ready = 1'b0;
        avs_write = 1'b1; avs_address = 24'h70; avs_writedata = 16'h7070;
        tick();
        avs_write = 1'b0; avs_read = 1'b1; avs_address = 24'h71;
        tick();
        avs_read = 1'b0;
        #1 chk("pre_rst_valid", 32'(bus_req_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus_req_valid), 32'd0);
        chk("mid_rst_idle", 32'(bridge_idle), 32'd1);
        chk("mid_rst_wait", 32'(avs_waitrequest), 32'd0);
        chk("mid_rst_err", 32'(resp_err), 32'd0);
        tick();
        reset_n = 1'b1;
        bus_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_valid", 32'(bus_req_valid), 32'd0);
            chk("post_rst_rdv", 32'(avs_readdatavalid), 32'd0);
            chk("post_rst_idle", 32'(bridge_idle), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
